// File: rtl/dac_spi_tx.sv
// SPI-style serial transmitter for a 12-bit DAC.
// Sends a 16-bit frame {2'b00, pd_mode, dac_data}, MSB first. The DAC samples on falling dac_sclk.
module dac_spi_tx #(
    parameter int CLK_DIV   = 4,
    parameter int SETUP_CYC = 2,
    parameter int GAP_CYC   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dac_trigger,
    input  logic [11:0] dac_data,
    input  logic [1:0]  pd_mode,
    output logic        dac_sclk,
    output logic        dac_sync_n,
    output logic        dac_din,
    output logic        busy,
    output logic        done
);

    // One 9-bit phase counter covers a full bit slot (up to 510 cycles) as well as the SETUP and GAP periods.
    localparam logic [8:0] HALF       = 9'(CLK_DIV);
    localparam logic [8:0] SLOT_LAST  = 9'(2 * CLK_DIV - 1);
    localparam logic [8:0] SETUP_LAST = 9'(SETUP_CYC - 1);
    localparam logic [8:0] GAP_LAST   = 9'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [8:0]  cnt_reg, cnt_next;
    logic [3:0]  bit_reg, bit_next;
    logic [15:0] frame_reg, frame_next;
    logic        sclk_next, sync_n_next, din_next, busy_next, done_next;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        frame_next = frame_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (dac_trigger) begin
                    state_next = SETUP;
                    cnt_next   = 9'd0;
                    bit_next   = 4'd15;
                    frame_next = {2'b00, pd_mode, dac_data};
                end
            end
            SETUP: begin
                if (cnt_reg == SETUP_LAST) begin
                    state_next = SHIFT;
                    cnt_next   = 9'd0;
                end else begin
                    cnt_next = cnt_reg + 9'd1;
                end
            end
            SHIFT: begin
                if (cnt_reg == SLOT_LAST) begin
                    cnt_next = 9'd0;
                    if (bit_reg == 4'd0) begin
                        state_next = GAP;
                    end else begin
                        bit_next = bit_reg - 4'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + 9'd1;
                end
            end
            GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    state_next = IDLE;
                    cnt_next   = 9'd0;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 9'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 9'd0;
            end
        endcase

        // Outputs are derived from the upcoming state so they register in step with it.
        sclk_next   = !((state_next == SHIFT) && (cnt_next >= HALF));
        sync_n_next = !((state_next == SETUP) || (state_next == SHIFT));
        din_next    = sync_n_next ? 1'b0 : frame_next[bit_next];
        busy_next   = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= 9'd0;
            bit_reg    <= 4'd0;
            frame_reg  <= 16'd0;
            dac_sclk   <= 1'b1;
            dac_sync_n <= 1'b1;
            dac_din    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            bit_reg    <= bit_next;
            frame_reg  <= frame_next;
            dac_sclk   <= sclk_next;
            dac_sync_n <= sync_n_next;
            dac_din    <= din_next;
            busy       <= busy_next;
            done       <= done_next;
        end
    end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed plus randomized bench for dac_spi_tx with a cycle-offset reference model.
module tb_dac_spi_tx;

    logic        clk;
    logic        rst;
    logic        dac_trigger;
    logic [11:0] dac_data;
    logic [1:0]  pd_mode;
    logic        dac_sclk;
    logic        dac_sync_n;
    logic        dac_din;
    logic        busy;
    logic        done;

    dac_spi_tx #(.CLK_DIV(4), .SETUP_CYC(2), .GAP_CYC(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .dac_trigger(dac_trigger),
        .dac_data   (dac_data),
        .pd_mode    (pd_mode),
        .dac_sclk   (dac_sclk),
        .dac_sync_n (dac_sync_n),
        .dac_din    (dac_din),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int SETUP_N = 2;
    localparam int SHIFT_N = 32 * 4;
    localparam int BUSY_N  = SETUP_N + SHIFT_N + 4;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    // Model state: k = cycles since the accepting edge (0 = idle).
    int          m_k    = 0;
    logic        m_done = 1'b0;
    logic [15:0] m_frame = 16'd0;

    // Capture of what the DAC would see on its falling sclk edges.
    logic        prev_sclk   = 1'b1;
    logic        prev_sync_n = 1'b1;
    logic        cap_on      = 1'b0;
    int          cap_cnt     = 0;
    logic [15:0] cap_word    = 16'd0;
    logic [15:0] last_word   = 16'd0;
    int          fall_cyc    = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [4:0] exp_out(input int k, input logic [15:0] f, input logic dn);
        int j;
        logic sc, sy, di, bz;
        sc = 1'b1; sy = 1'b1; di = 1'b0; bz = 1'b0;
        if (k >= 1 && k <= SETUP_N) begin
            sy = 1'b0; bz = 1'b1; di = f[15];
        end else if (k > SETUP_N && k <= SETUP_N + SHIFT_N) begin
            j  = k - SETUP_N - 1;
            sy = 1'b0; bz = 1'b1;
            sc = ((j % 8) < 4);
            di = f[15 - j / 8];
        end else if (k > SETUP_N + SHIFT_N) begin
            bz = 1'b1;
        end
        return {sc, sy, di, bz, (k == 0) ? dn : 1'b0};
    endfunction

    task automatic step(input logic t, input logic r, input logic [11:0] d, input logic [1:0] p);
        logic [4:0] e;
        dac_trigger = t;
        rst         = r;
        dac_data    = d;
        pd_mode     = p;
        @(posedge clk);
        cyc++;
        if (r) begin
            m_k = 0; m_done = 1'b0;
        end else if (m_k == 0) begin
            m_done = 1'b0;
            if (t) begin
                m_k = 1; m_frame = {2'b00, p, d};
            end
        end else if (m_k == BUSY_N) begin
            m_k = 0; m_done = 1'b1;
        end else begin
            m_k++;
        end
        #1;
        e = exp_out(m_k, m_frame, m_done);
        chk("sclk",   {15'd0, dac_sclk},   {15'd0, e[4]});
        chk("sync_n", {15'd0, dac_sync_n}, {15'd0, e[3]});
        chk("din",    {15'd0, dac_din},    {15'd0, e[2]});
        chk("busy",   {15'd0, busy},       {15'd0, e[1]});
        chk("done",   {15'd0, done},       {15'd0, e[0]});

        if (r) cap_on = 1'b0;
        if (prev_sync_n && !dac_sync_n) begin
            cap_on = 1'b1; cap_cnt = 0; cap_word = 16'd0; fall_cyc = cyc;
        end
        if (cap_on && prev_sclk && !dac_sclk && !dac_sync_n) begin
            cap_word = {cap_word[14:0], dac_din};
            cap_cnt++;
        end
        if (cap_on && !prev_sync_n && dac_sync_n) begin
            chk("fall_edges", 16'(cap_cnt), 16'd16);
            chk("frame_word", cap_word, m_frame);
            last_word = cap_word;
            cap_on = 1'b0;
        end
        prev_sclk   = dac_sclk;
        prev_sync_n = dac_sync_n;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 12'h000, 2'b00);
    endtask

    initial begin
        int f1;
        dac_trigger = 1'b0; rst = 1'b1; dac_data = 12'h000; pd_mode = 2'b00;

        // Reset held 3 cycles, with trigger asserted to confirm it is ignored.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 12'hFFF, 2'b11);
        $display("reset: 3 cycles checked");
        idle_steps(3);

        // Basic frame.
        step(1'b1, 1'b0, 12'hA5C, 2'b00);
        idle_steps(BUSY_N + 2);
        chk("basic_word", last_word, 16'h0A5C);
        $display("basic frame: word=%h", last_word);

        // Power-down bits.
        step(1'b1, 1'b0, 12'hFFF, 2'b11);
        idle_steps(BUSY_N + 2);
        chk("pd_word", last_word, 16'h3FFF);
        $display("pd frame: word=%h", last_word);

        // Input isolation: retrigger and new data mid-frame.
        step(1'b1, 1'b0, 12'h5A3, 2'b01);
        idle_steps(38);
        step(1'b1, 1'b0, 12'h123, 2'b10);
        for (int i = 0; i < BUSY_N; i++) step(1'b0, 1'b0, 12'h123, 2'b10);
        chk("iso_word", last_word, 16'h15A3);
        $display("isolation frame: word=%h", last_word);
        idle_steps(2);

        // Back-to-back: retrigger in the done cycle.
        step(1'b1, 1'b0, 12'h3C7, 2'b10);
        f1 = fall_cyc;
        idle_steps(BUSY_N);
        step(1'b1, 1'b0, 12'h0F1, 2'b01);
        chk("b2b_fall_spacing", 16'(fall_cyc - f1), 16'd135);
        idle_steps(BUSY_N + 2);
        chk("b2b_word2", last_word, 16'h10F1);
        $display("back-to-back: spacing=%0d word2=%h", fall_cyc - f1, last_word);

        // Reset mid-frame, then a clean frame.
        step(1'b1, 1'b0, 12'h777, 2'b11);
        idle_steps(49);
        step(1'b0, 1'b1, 12'h000, 2'b00);
        idle_steps(BUSY_N + 4);
        step(1'b1, 1'b0, 12'h9E4, 2'b01);
        idle_steps(BUSY_N + 2);
        chk("post_abort_word", last_word, 16'h19E4);
        $display("abort + restart: word=%h", last_word);

        // Trigger held high continuously.
        for (int i = 0; i < 3 * (BUSY_N + 1); i++)
            step(1'b1, 1'b0, 12'($urandom), 2'($urandom));
        $display("held trigger: 3 frames");

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++)
            step(($urandom_range(0, 9) == 0), ($urandom_range(0, 299) == 0),
                 12'($urandom), 2'($urandom));
        idle_steps(BUSY_N + 2);
        $display("random: done at cycle %0d", cyc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
